// File: rtl/regfile_port_ctrl_pkg.sv
// Shared register-file constants: x0 index and default data/address widths.
// Also used by the register file and decode.
package regfile_port_ctrl_pkg;

  localparam int DATA_WIDTH_D = 32;
  localparam int ADDR_WIDTH_D = 5;
  localparam int REG_ZERO     = 0;

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// Bundle of decode, execute, writeback and register-file signals seen by
// the register-file port controller.
interface regfile_port_ctrl_if
  import regfile_port_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH_P = DATA_WIDTH_D,
  parameter int ADDR_WIDTH_P = ADDR_WIDTH_D
);

  // Handshakes: a transfer happens at a posedge where valid & ready are both
  // high; valid never depends on ready, and payload is stable while valid & !ready.
  logic                    i_req_valid;
  logic                    o_req_ready;
  logic [ADDR_WIDTH_P-1:0] i_rs1;
  logic [ADDR_WIDTH_P-1:0] i_rs2;

  logic                    o_op_valid;
  logic                    i_op_ready;
  logic [DATA_WIDTH_P-1:0] o_op_a;
  logic [DATA_WIDTH_P-1:0] o_op_b;

  logic                    i_wb_valid;
  logic [ADDR_WIDTH_P-1:0] i_wb_rd;
  logic [DATA_WIDTH_P-1:0] i_wb_data;

  logic [ADDR_WIDTH_P-1:0] o_rf_rd_addr_a;
  logic [ADDR_WIDTH_P-1:0] o_rf_rd_addr_b;
  logic [DATA_WIDTH_P-1:0] i_rf_rd_data_a;
  logic [DATA_WIDTH_P-1:0] i_rf_rd_data_b;
  logic [ADDR_WIDTH_P-1:0] o_rf_wr_addr;
  logic [DATA_WIDTH_P-1:0] o_rf_wr_data;
  logic                    o_rf_wr_enable;

  modport slave (
    input  i_req_valid, i_rs1, i_rs2, i_op_ready,
    input  i_wb_valid, i_wb_rd, i_wb_data,
    input  i_rf_rd_data_a, i_rf_rd_data_b,
    output o_req_ready, o_op_valid, o_op_a, o_op_b,
    output o_rf_rd_addr_a, o_rf_rd_addr_b,
    output o_rf_wr_addr, o_rf_wr_data, o_rf_wr_enable
  );

  modport master (
    output i_req_valid, i_rs1, i_rs2, i_op_ready,
    output i_wb_valid, i_wb_rd, i_wb_data,
    output i_rf_rd_data_a, i_rf_rd_data_b,
    input  o_req_ready, o_op_valid, o_op_a, o_op_b,
    input  o_rf_rd_addr_a, o_rf_rd_addr_b,
    input  o_rf_wr_addr, o_rf_wr_data, o_rf_wr_enable
  );

endinterface

// File: rtl/regfile_port_ctrl_fwd_sel.sv
// Per-operand forwarding: remembers a writeback that raced the file read and
// picks the operand value when S1 advances.
module regfile_fwd_sel
  import regfile_port_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH_P = DATA_WIDTH_D,
  parameter int ADDR_WIDTH_P = ADDR_WIDTH_D
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH_P-1:0] rd_addr,
  input  logic [ADDR_WIDTH_P-1:0] s1_rs,
  input  logic                    wb_valid,
  input  logic [ADDR_WIDTH_P-1:0] wb_rd,
  input  logic [DATA_WIDTH_P-1:0] wb_data,
  input  logic [DATA_WIDTH_P-1:0] rf_rd_data,
  output logic [DATA_WIDTH_P-1:0] sel_data
);

  logic                    fwd_q;
  logic [DATA_WIDTH_P-1:0] fwd_data_q;

  // The file is read-before-write, so a write landing on the read edge is
  // invisible in rf_rd_data next cycle; capture it here instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= wb_valid && (wb_rd == rd_addr) &&
                    (rd_addr != ADDR_WIDTH_P'(REG_ZERO));
      fwd_data_q <= wb_data;
    end
  end

  always_comb begin
    sel_data = rf_rd_data;
    if (s1_rs == ADDR_WIDTH_P'(REG_ZERO)) begin
      sel_data = '0;
    end else if (wb_valid && (wb_rd == s1_rs)) begin
      sel_data = wb_data;
    end else if (fwd_q) begin
      sel_data = fwd_data_q;
    end
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Two-stage read controller (S1 read issued, OUT operands held) for a
// 2R/1W register file with synchronous read, forwarding and x0 handling.
module regfile_port_ctrl
  import regfile_port_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH_P = DATA_WIDTH_D,
  parameter int ADDR_WIDTH_P = ADDR_WIDTH_D
) (
  input logic                 clk,
  input logic                 reset,
  regfile_port_ctrl_if.slave  bus
);

  logic                    s1_valid;
  logic [ADDR_WIDTH_P-1:0] s1_rs1;
  logic [ADDR_WIDTH_P-1:0] s1_rs2;

  logic                    op_valid_q;
  logic [DATA_WIDTH_P-1:0] op_a_q;
  logic [DATA_WIDTH_P-1:0] op_b_q;
  logic [ADDR_WIDTH_P-1:0] out_rs1;
  logic [ADDR_WIDTH_P-1:0] out_rs2;

  logic                    out_free;
  logic                    req_ready;
  logic [ADDR_WIDTH_P-1:0] rd_addr_a;
  logic [ADDR_WIDTH_P-1:0] rd_addr_b;
  logic [DATA_WIDTH_P-1:0] sel_a;
  logic [DATA_WIDTH_P-1:0] sel_b;
  logic                    wb_nz;
  logic                    hold_hit_a;
  logic                    hold_hit_b;

  assign out_free  = !op_valid_q || bus.i_op_ready;
  assign req_ready = !reset && (!s1_valid || out_free);

  // A stalled S1 keeps re-reading its own registers so the file data stays fresh.
  assign rd_addr_a = req_ready ? bus.i_rs1 : s1_rs1;
  assign rd_addr_b = req_ready ? bus.i_rs2 : s1_rs2;

  assign wb_nz      = bus.i_wb_valid && (bus.i_wb_rd != ADDR_WIDTH_P'(REG_ZERO));
  assign hold_hit_a = wb_nz && (bus.i_wb_rd == out_rs1);
  assign hold_hit_b = wb_nz && (bus.i_wb_rd == out_rs2);

  regfile_fwd_sel #(
    .DATA_WIDTH_P (DATA_WIDTH_P),
    .ADDR_WIDTH_P (ADDR_WIDTH_P)
  ) u_fwd_a (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr_a),
    .s1_rs      (s1_rs1),
    .wb_valid   (bus.i_wb_valid),
    .wb_rd      (bus.i_wb_rd),
    .wb_data    (bus.i_wb_data),
    .rf_rd_data (bus.i_rf_rd_data_a),
    .sel_data   (sel_a)
  );

  regfile_fwd_sel #(
    .DATA_WIDTH_P (DATA_WIDTH_P),
    .ADDR_WIDTH_P (ADDR_WIDTH_P)
  ) u_fwd_b (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr_b),
    .s1_rs      (s1_rs2),
    .wb_valid   (bus.i_wb_valid),
    .wb_rd      (bus.i_wb_rd),
    .wb_data    (bus.i_wb_data),
    .rf_rd_data (bus.i_rf_rd_data_b),
    .sel_data   (sel_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
    end else if (req_ready) begin
      s1_valid <= bus.i_req_valid;
      s1_rs1   <= bus.i_rs1;
      s1_rs2   <= bus.i_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      out_rs1    <= '0;
      out_rs2    <= '0;
    end else if (out_free) begin
      op_valid_q <= s1_valid;
      if (s1_valid) begin
        op_a_q  <= sel_a;
        op_b_q  <= sel_b;
        out_rs1 <= s1_rs1;
        out_rs2 <= s1_rs2;
      end
    end else begin
      // Held operands track writebacks so execute never consumes a stale value.
      if (hold_hit_a) op_a_q <= bus.i_wb_data;
      if (hold_hit_b) op_b_q <= bus.i_wb_data;
    end
  end

  assign bus.o_req_ready    = req_ready;
  assign bus.o_op_valid     = op_valid_q;
  assign bus.o_op_a         = op_a_q;
  assign bus.o_op_b         = op_b_q;
  assign bus.o_rf_rd_addr_a = rd_addr_a;
  assign bus.o_rf_rd_addr_b = rd_addr_b;
  assign bus.o_rf_wr_addr   = bus.i_wb_rd;
  assign bus.o_rf_wr_data   = bus.i_wb_data;
  assign bus.o_rf_wr_enable = wb_nz && !reset;

endmodule
